fsm_input_cond: RTL and testbench
=================================

FSM_INPUT_COND -- requirements
Module: fsm_input_cond

Interface
REQ-001 Parameter: DB_LEN, default 4, number of consecutive synchronized cycles an input must hold a new value before it is accepted; legal range 1..255.
REQ-002 Port: clk  input  1  single rising-edge clock for all flops.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low; all flops clear while low.
REQ-004 Port: a_raw  input  1  asynchronous switch input, channel a.
REQ-005 Port: b_raw  input  1  asynchronous switch input, channel b.
REQ-006 Port: c_raw  input  1  asynchronous switch input, channel c.
REQ-007 Port: hold  input  1  synchronous freeze; while high, debounce counters and outputs keep their values.
REQ-008 Port: a, b, c  output  1 each  registered, debounced levels; these drive the a/b/c inputs of the downstream sequence FSM.
REQ-009 Port: chg  output  1  registered one-cycle strobe; high in the cycle in which any of a/b/c took a new value.
REQ-010 Port: idle  output  1  combinational ~a & ~b & ~c; mirrors the downstream FSM return-to-idle condition.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer (s1, s2); no other logic SHALL read the raw inputs or s1.
REQ-012 Each channel SHALL own an independent counter of width ceil(log2(DB_LEN))+1 bits.
REQ-013 Per channel, per rising edge, hold low: if s2 == out, then cnt <= 0; else if cnt == DB_LEN-1, then out <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-014 Latency: a raw level that is stable and first sampled into s1 at edge t0 SHALL appear on the output at edge t0+1+DB_LEN (6th edge, counting t0 as the 1st, for DB_LEN=4).
REQ-015 A pulse visible on s2 for fewer than DB_LEN consecutive cycles SHALL NOT change the output; its counter SHALL return to 0 on the first cycle s2 again equals out.
REQ-016 DB_LEN=1: the output SHALL update on the first edge at which s2 differs from out.
REQ-017 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted on their own schedule, and outputs accepted on the same edge SHALL update on that same edge.
REQ-018 chg SHALL be set on an edge iff at least one output bit changes on that edge; otherwise chg SHALL be cleared on that edge; chg SHALL never stay high for two cycles due to a single acceptance.
REQ-019 hold high: counters, outputs and chg hold their values except chg, which SHALL be cleared; s1/s2 SHALL continue sampling.
REQ-020 hold low again: counting SHALL resume from the frozen count against the current s2.
REQ-021 A counter SHALL never exceed DB_LEN-1; no wrap-around SHALL be possible.

Reset
REQ-022 While rst_n low: s1, s2, all counters, a, b, c, chg = 0; idle = 1.
REQ-023 Reset assertion mid-count SHALL discard the partial count; after release, an input already high SHALL need the full 2+DB_LEN cycles to be accepted.
REQ-024 Reset deassertion SHALL be the only source of an out-of-phase update; no output SHALL toggle on the release edge itself.

Verification
REQ-025 DB_LEN=4, rst_n released, b_raw 0->1 held: b=1 and chg=1 on the 6th edge after b_raw is first sampled; chg=0 on the next edge; idle 1->0 with b.
REQ-026 DB_LEN=4, a_raw high for 3 cycles then low: a stays 0, chg never asserts, a counter returns to 0.
REQ-027 a_raw and b_raw rise on the same cycle: a and b rise on the same edge with a single 1-cycle chg; then c_raw rises 2 cycles later: c rises 2 edges after a/b with a second chg pulse.
REQ-028 b_raw rises; hold=1 for 10 cycles after 2 counts: b stays 0. Release hold: b=1 exactly 2 edges later.
REQ-029 a=b=c=1 steady, rst_n pulsed low mid-operation: all outputs 0 and idle=1 immediately (asynchronous); after release, outputs return to 1 after 2+DB_LEN edges.
REQ-030 DB_LEN=1 sweep: raw toggle every 4 cycles: each output follows with exactly 3-edge latency, with one chg per toggle.

Source files
------------

// File: rtl/fsm_input_cond.sv
// rtl/fsm_input_cond.sv - synchronize and debounce three switch inputs feeding the sequence FSM
// Each channel: 2-flop synchronizer, saturating debounce counter, registered output.
module fsm_input_cond #(
    parameter int DB_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_raw,
    input  logic b_raw,
    input  logic c_raw,
    input  logic hold,
    output logic a,
    output logic b,
    output logic c,
    output logic chg,
    output logic idle
);

    localparam int CW = $clog2(DB_LEN) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [2:0]         s1_q, s1_d;
    logic [2:0]         s2_q, s2_d;
    logic [2:0]         out_q, out_d;
    logic [2:0][CW-1:0] cnt_q, cnt_d;
    logic               chg_q, chg_d;

    always_comb begin
        s1_d  = {c_raw, b_raw, a_raw};
        s2_d  = s1_q;
        out_d = out_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (!hold) begin
                if (s2_q[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    out_d[i] = s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        // out_d never differs from out_q while frozen, so chg also clears under hold
        chg_d = (out_d != out_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= '0;
            s2_q  <= '0;
            out_q <= '0;
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            out_q <= out_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign a    = out_q[0];
    assign b    = out_q[1];
    assign c    = out_q[2];
    assign chg  = chg_q;
    assign idle = ~out_q[0] & ~out_q[1] & ~out_q[2];

endmodule

// File: tb/tb_fsm_input_cond.sv
// tb/tb_fsm_input_cond.sv - directed vector bench for fsm_input_cond (DB_LEN=4 and DB_LEN=1)
module tb_fsm_input_cond;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_raw = 1'b0, b_raw = 1'b0, c_raw = 1'b0, hold = 1'b0;
    logic a, b, c, chg, idle;
    logic d1_a_raw = 1'b0, d1_b_raw = 1'b0, d1_c_raw = 1'b0, d1_hold = 1'b0;
    logic d1_a, d1_b, d1_c, d1_chg, d1_idle;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsm_input_cond #(.DB_LEN(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_raw(a_raw), .b_raw(b_raw), .c_raw(c_raw), .hold(hold),
        .a(a), .b(b), .c(c), .chg(chg), .idle(idle)
    );

    fsm_input_cond #(.DB_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .a_raw(d1_a_raw), .b_raw(d1_b_raw), .c_raw(d1_c_raw), .hold(d1_hold),
        .a(d1_a), .b(d1_b), .c(d1_c), .chg(d1_chg), .idle(d1_idle)
    );

    // in = {hold, c_raw, b_raw, a_raw}; exp = {a, b, c, chg, idle}
    typedef struct {
        string      tag;
        logic [3:0] in;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic [3:0] in, input logic [4:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.tag = tag;
            v.in  = in;
            v.exp = exp;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (a b c chg idle) at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [4:0] exp_o;
        logic [2:0] hist[$];
        logic [2:0] prev_o, cur_o;

        // reset state, while rst_n is low
        repeat (3) @(posedge clk);
        #1;
        check("reset_db4", {a, b, c, chg, idle}, 5'b00001);
        check("reset_db1", {d1_a, d1_b, d1_c, d1_chg, d1_idle}, 5'b00001);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("post_release", {a, b, c, chg, idle}, 5'b00001);
        end

        // b rise/fall latency
        add("b_rise", 4'b0010, 5'b00001, 5);
        add("b_rise", 4'b0010, 5'b01010, 1);
        add("b_rise", 4'b0010, 5'b01000, 1);
        add("b_fall", 4'b0000, 5'b01000, 5);
        add("b_fall", 4'b0000, 5'b00011, 1);
        add("b_fall", 4'b0000, 5'b00001, 1);
        // short a pulse rejected; counter must restart from 0 for the next real rise
        add("a_glitch", 4'b0001, 5'b00001, 3);
        add("a_glitch", 4'b0000, 5'b00001, 4);
        add("a_rise", 4'b0001, 5'b00001, 5);
        add("a_rise", 4'b0001, 5'b10010, 1);
        add("a_rise", 4'b0001, 5'b10000, 1);
        add("a_fall", 4'b0000, 5'b10000, 5);
        add("a_fall", 4'b0000, 5'b00011, 1);
        add("a_fall", 4'b0000, 5'b00001, 1);
        // hold freezes after two counts, resumes from the frozen count
        add("hold_pre", 4'b0010, 5'b00001, 4);
        add("hold_on", 4'b1010, 5'b00001, 10);
        add("hold_off", 4'b0010, 5'b00001, 1);
        add("hold_off", 4'b0010, 5'b01010, 1);
        add("hold_off", 4'b0010, 5'b01000, 1);
        // hold on the would-be acceptance edge delays it by one cycle
        add("hold_acc", 4'b0000, 5'b01000, 5);
        add("hold_acc", 4'b1000, 5'b01000, 1);
        add("hold_acc", 4'b0000, 5'b00011, 1);
        add("hold_acc", 4'b0000, 5'b00001, 1);
        // a and b together, c two cycles later
        add("abc", 4'b0011, 5'b00001, 2);
        add("abc", 4'b0111, 5'b00001, 3);
        add("abc", 4'b0111, 5'b11010, 1);
        add("abc", 4'b0111, 5'b11000, 1);
        add("abc", 4'b0111, 5'b11110, 1);
        add("abc", 4'b0111, 5'b11100, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            {hold, c_raw, b_raw, a_raw} = vecs[i].in;
            @(posedge clk);
            #1;
            check(vecs[i].tag, {a, b, c, chg, idle}, vecs[i].exp);
        end

        // asynchronous reset mid-operation with all inputs high
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {a, b, c, chg, idle}, 5'b00001);
        @(posedge clk);
        #1;
        check("rst_held", {a, b, c, chg, idle}, 5'b00001);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (k < 6)       exp_o = 5'b00001;
            else if (k == 6) exp_o = 5'b11110;
            else             exp_o = 5'b11100;
            check($sformatf("rst_recover_e%0d", k), {a, b, c, chg, idle}, exp_o);
        end

        // DB_LEN=1: staggered toggles every 4 cycles, output = raw from two rows earlier
        prev_o = 3'b000;
        for (int n = 0; n < 32; n++) begin
            @(negedge clk);
            d1_a_raw = ((n / 4) % 2) == 1;
            d1_b_raw = (((n + 1) / 4) % 2) == 1;
            d1_c_raw = (((n + 2) / 4) % 2) == 1;
            hist.push_back({d1_c_raw, d1_b_raw, d1_a_raw});
            @(posedge clk);
            #1;
            cur_o = (n >= 2) ? hist[n - 2] : 3'b000;
            exp_o = {cur_o[0], cur_o[1], cur_o[2], cur_o != prev_o, cur_o == 3'b000};
            check($sformatf("db1_sweep_%0d", n), {d1_a, d1_b, d1_c, d1_chg, d1_idle}, exp_o);
            prev_o = cur_o;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
